// File: rtl/wb_stage_if.sv
// Execute-to-writeback bus and register-file write port of the writeback stage.
// slave = the writeback stage; master = the upstream execute/memory side.
interface wb_stage_if #(
    parameter int XLEN = 32
);
    logic            x_valid;
    logic [4:0]      x_rd;
    logic            x_reg_wen;
    logic [1:0]      x_wb_sel;
    logic [2:0]      x_funct3;
    logic [XLEN-1:0] x_alu;
    logic [XLEN-1:0] x_pc4;
    logic [XLEN-1:0] x_imm;
    logic            rf_we;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd;

    modport master (
        output x_valid, x_rd, x_reg_wen, x_wb_sel, x_funct3, x_alu, x_pc4, x_imm,
        input  rf_we, rf_wa, rf_wd
    );

    modport slave (
        input  x_valid, x_rd, x_reg_wen, x_wb_sel, x_funct3, x_alu, x_pc4, x_imm,
        output rf_we, rf_wa, rf_wd
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: stage register, load alignment, writeback select, retired-instruction counter.
// Define WB_FWD_EN to bypass the in-flight register-file write onto the decode read ports.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    wb_stage_if.slave        wb,
    input  logic [XLEN-1:0]  dmem_dout,
    output logic [CNT_W-1:0] instret,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [XLEN-1:0]  rd1_raw,
    input  logic [XLEN-1:0]  rd2_raw,
    output logic [XLEN-1:0]  rd1_fwd,
    output logic [XLEN-1:0]  rd2_fwd
);
    logic            valid_q;
    logic [4:0]      rd_q;
    logic            wen_q;
    logic [1:0]      sel_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] pc4_q;
    logic [XLEN-1:0] imm_q;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] wd;
    logic            we;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            sel_q   <= '0;
            f3_q    <= '0;
            alu_q   <= '0;
            pc4_q   <= '0;
            imm_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q <= wb.x_valid;
            rd_q    <= wb.x_rd;
            wen_q   <= wb.x_reg_wen;
            sel_q   <= wb.x_wb_sel;
            f3_q    <= wb.x_funct3;
            alu_q   <= wb.x_alu;
            pc4_q   <= wb.x_pc4;
            imm_q   <= wb.x_imm;
        end
    end

    // Counts whatever sits in the stage on an unstalled edge, including x0 and no-write ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
        end else if (valid_q && !stall) begin
            instret <= instret + CNT_W'(1);
        end
    end

    // Halfword select uses only alu[1]; a misaligned alu[0] is silently ignored.
    always_comb begin
        ld_byte = dmem_dout[{alu_q[1:0], 3'b000} +: 8];
        ld_half = dmem_dout[{alu_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'd0:    ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'd4:    ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'd1:    ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'd5:    ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = dmem_dout;
        endcase
    end

    always_comb begin
        case (sel_q)
            2'd0:    wd = alu_q;
            2'd1:    wd = ld_data;
            2'd2:    wd = pc4_q;
            default: wd = imm_q;
        endcase
    end

    assign we       = valid_q & wen_q & (rd_q != 5'd0);
    assign wb.rf_we = we;
    assign wb.rf_wa = rd_q;
    assign wb.rf_wd = wd;

`ifdef WB_FWD_EN
    assign rd1_fwd = (we && rs1 == rd_q) ? wd : rd1_raw;
    assign rd2_fwd = (we && rs2 == rd_q) ? wd : rd2_raw;
`else
    logic unused_rs;
    assign unused_rs = ^{rs1, rs2};
    assign rd1_fwd   = rd1_raw;
    assign rd2_fwd   = rd2_raw;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table with scoreboard, plus stall/flush/reset/wrap/forwarding sequences.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] dmem_dout;
    logic [31:0] instret;
    logic [3:0]  instret4;
    logic [4:0]  rs1, rs2;
    logic [31:0] rd1_raw, rd2_raw, rd1_fwd, rd2_fwd, rd1_fwd4, rd2_fwd4;

    wb_stage_if #(.XLEN(32)) wb ();
    wb_stage_if #(.XLEN(32)) wb4 ();

    assign wb4.x_valid   = wb.x_valid;
    assign wb4.x_rd      = wb.x_rd;
    assign wb4.x_reg_wen = wb.x_reg_wen;
    assign wb4.x_wb_sel  = wb.x_wb_sel;
    assign wb4.x_funct3  = wb.x_funct3;
    assign wb4.x_alu     = wb.x_alu;
    assign wb4.x_pc4     = wb.x_pc4;
    assign wb4.x_imm     = wb.x_imm;

    wb_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .wb(wb),
        .dmem_dout(dmem_dout), .instret(instret), .rs1(rs1), .rs2(rs2),
        .rd1_raw(rd1_raw), .rd2_raw(rd2_raw), .rd1_fwd(rd1_fwd), .rd2_fwd(rd2_fwd)
    );

    wb_stage #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .wb(wb4),
        .dmem_dout(dmem_dout), .instret(instret4), .rs1(rs1), .rs2(rs2),
        .rd1_raw(rd1_raw), .rd2_raw(rd2_raw), .rd1_fwd(rd1_fwd4), .rd2_fwd(rd2_fwd4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic        wen;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] dout;
        logic        ewe;
        logic [31:0] ewd;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] dout;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_cnt = '0;

    function automatic vec_t mk(logic v, logic [4:0] rd, logic wen, logic [1:0] sel, logic [2:0] f3,
                                logic [31:0] alu, logic [31:0] dout, logic ewe, logic [31:0] ewd);
        vec_t t;
        t.valid = v; t.rd = rd; t.wen = wen; t.sel = sel; t.f3 = f3;
        t.alu = alu; t.dout = dout; t.ewe = ewe; t.ewd = ewd;
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [4:0] rd, logic wen, logic [1:0] sel, logic [2:0] f3, logic [31:0] alu);
        wb.x_valid = v; wb.x_rd = rd; wb.x_reg_wen = wen; wb.x_wb_sel = sel;
        wb.x_funct3 = f3; wb.x_alu = alu; wb.x_pc4 = 32'h0000_0104; wb.x_imm = 32'hABCD_E000;
    endtask

    // Reference model of valid/instret, advanced with the inputs present at the coming edge.
    task automatic tick();
        if (rst) begin
            m_valid = 1'b0;
            m_cnt   = '0;
        end else begin
            if (m_valid && !stall) m_cnt = m_cnt + 1;
            if (flush) m_valid = 1'b0;
            else if (!stall) m_valid = wb.x_valid;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t        e;
        logic [31:0] held;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; dmem_dout = '0;
        rs1 = '0; rs2 = '0; rd1_raw = '0; rd2_raw = '0;
        drive(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'h0);
        @(negedge clk);

        // Reset then idle
        tick(); tick();
        check("reset_we", {31'b0, wb.rf_we}, 32'd0);
        check("reset_wa", {27'b0, wb.rf_wa}, 32'd0);
        check("reset_wd", wb.rf_wd, 32'd0);
        check("reset_instret", instret, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_instret", instret, m_cnt);
            @(negedge clk);
        end

        // Vector table: dmem word 0x80FF_7F01 for load cases
        vecs.push_back(mk(1, 5'd5,  1, 2'd0, 3'd0, 32'h1234_5678, 32'h0,         1, 32'h1234_5678));
        vecs.push_back(mk(1, 5'd6,  1, 2'd1, 3'd0, 32'h0000_1003, 32'h80FF_7F01, 1, 32'hFFFF_FF80));
        vecs.push_back(mk(1, 5'd6,  1, 2'd1, 3'd4, 32'h0000_1001, 32'h80FF_7F01, 1, 32'h0000_007F));
        vecs.push_back(mk(1, 5'd6,  1, 2'd1, 3'd1, 32'h0000_1002, 32'h80FF_7F01, 1, 32'hFFFF_80FF));
        vecs.push_back(mk(1, 5'd6,  1, 2'd1, 3'd5, 32'h0000_1002, 32'h80FF_7F01, 1, 32'h0000_80FF));
        vecs.push_back(mk(1, 5'd6,  1, 2'd1, 3'd1, 32'h0000_1003, 32'h80FF_7F01, 1, 32'hFFFF_80FF));
        vecs.push_back(mk(1, 5'd6,  1, 2'd1, 3'd5, 32'h0000_1001, 32'h80FF_7F01, 1, 32'h0000_7F01));
        vecs.push_back(mk(1, 5'd6,  1, 2'd1, 3'd1, 32'h0000_1000, 32'h80FF_7F01, 1, 32'h0000_7F01));
        vecs.push_back(mk(1, 5'd6,  1, 2'd1, 3'd0, 32'h0000_1000, 32'h80FF_7F01, 1, 32'h0000_0001));
        vecs.push_back(mk(1, 5'd6,  1, 2'd1, 3'd0, 32'h0000_1002, 32'h80FF_7F01, 1, 32'hFFFF_FFFF));
        vecs.push_back(mk(1, 5'd6,  1, 2'd1, 3'd4, 32'h0000_1002, 32'h80FF_7F01, 1, 32'h0000_00FF));
        vecs.push_back(mk(1, 5'd6,  1, 2'd1, 3'd2, 32'h0000_1000, 32'h80FF_7F01, 1, 32'h80FF_7F01));
        vecs.push_back(mk(1, 5'd6,  1, 2'd1, 3'd3, 32'h0000_1001, 32'h80FF_7F01, 1, 32'h80FF_7F01));
        vecs.push_back(mk(1, 5'd6,  1, 2'd1, 3'd7, 32'h0000_1003, 32'h80FF_7F01, 1, 32'h80FF_7F01));
        vecs.push_back(mk(1, 5'd8,  1, 2'd2, 3'd0, 32'h0000_0000, 32'h0,         1, 32'h0000_0104));
        vecs.push_back(mk(1, 5'd9,  1, 2'd3, 3'd0, 32'h0000_0000, 32'h0,         1, 32'hABCD_E000));
        vecs.push_back(mk(1, 5'd0,  1, 2'd0, 3'd0, 32'h0000_00AA, 32'h0,         0, 32'h0000_00AA));
        vecs.push_back(mk(1, 5'd9,  0, 2'd0, 3'd0, 32'h0000_00BB, 32'h0,         0, 32'h0000_00BB));
        vecs.push_back(mk(0, 5'd3,  1, 2'd0, 3'd0, 32'h0000_00CC, 32'h0,         0, 32'h0000_00CC));
        vecs.push_back(mk(1, 5'd31, 1, 2'd0, 3'd0, 32'hFFFF_FFFF, 32'h0,         1, 32'hFFFF_FFFF));

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].rd, vecs[i].wen, vecs[i].sel, vecs[i].f3, vecs[i].alu);
            sbq.push_back('{we: vecs[i].ewe, wa: vecs[i].rd, wd: vecs[i].ewd, dout: vecs[i].dout});
            tick();
            e = sbq.pop_front();
            dmem_dout = e.dout;
            #1;
            check($sformatf("vec%0d_we", i), {31'b0, wb.rf_we}, {31'b0, e.we});
            check($sformatf("vec%0d_wa", i), {27'b0, wb.rf_wa}, {27'b0, e.wa});
            check($sformatf("vec%0d_wd", i), wb.rf_wd, e.wd);
            check($sformatf("vec%0d_instret", i), instret, m_cnt);
            @(negedge clk);
        end

        // Stall holds the stage and freezes instret
        drive(1, 5'd11, 1, 2'd0, 3'd0, 32'hCAFE_0000);
        tick();
        check("stall_pre_wa", {27'b0, wb.rf_wa}, 32'd11);
        @(negedge clk);
        held = m_cnt;
        stall = 1'b1;
        drive(1, 5'd13, 1, 2'd0, 3'd0, 32'h1111_1111);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_we", {31'b0, wb.rf_we}, 32'd1);
            check("stall_wa", {27'b0, wb.rf_wa}, 32'd11);
            check("stall_wd", wb.rf_wd, 32'hCAFE_0000);
            check("stall_instret", instret, held);
            @(negedge clk);
        end
        stall = 1'b0;
        tick();
        check("unstall_wa", {27'b0, wb.rf_wa}, 32'd13);
        check("unstall_instret", instret, m_cnt);
        @(negedge clk);

        // Flush beats stall
        drive(1, 5'd14, 1, 2'd0, 3'd0, 32'h0000_0014);
        tick();
        check("flush_pre_we", {31'b0, wb.rf_we}, 32'd1);
        @(negedge clk);
        stall = 1'b1; flush = 1'b1;
        tick();
        check("flush_we", {31'b0, wb.rf_we}, 32'd0);
        check("flush_instret", instret, m_cnt);
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        drive(0, 5'd0, 1'b0, 2'd0, 3'd0, 32'h0);
        tick();
        @(negedge clk);

        // Reset mid-operation
        drive(1, 5'd12, 1, 2'd0, 3'd0, 32'h0000_0077);
        tick();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 5'd0, 1'b0, 2'd0, 3'd0, 32'h0);
        #1;
        check("rstmid_pre_we", {31'b0, wb.rf_we}, 32'd1);
        tick();
        check("rstmid_we", {31'b0, wb.rf_we}, 32'd0);
        check("rstmid_wa", {27'b0, wb.rf_wa}, 32'd0);
        check("rstmid_wd", wb.rf_wd, 32'd0);
        check("rstmid_instret", instret, 32'd0);
        check("rstmid_instret4", {28'b0, instret4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 17 retirements wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            drive(1, 5'd1, 1, 2'd0, 3'd0, i);
            tick();
            @(negedge clk);
        end
        drive(0, 5'd0, 1'b0, 2'd0, 3'd0, 32'h0);
        tick();
        check("wrap_instret4", {28'b0, instret4}, 32'd1);
        check("wrap_instret", instret, m_cnt);
        @(negedge clk);

        // Forwarding ports
        drive(1, 5'd7, 1, 2'd0, 3'd0, 32'hDEAD_BEEF);
        tick();
        rs1 = 5'd7; rd1_raw = 32'h0; rs2 = 5'd8; rd2_raw = 32'h5555_AAAA;
        #1;
`ifdef WB_FWD_EN
        check("fwd_rd1", rd1_fwd, 32'hDEAD_BEEF);
`else
        check("fwd_rd1", rd1_fwd, 32'h0);
`endif
        check("fwd_rd2_nomatch", rd2_fwd, 32'h5555_AAAA);
        rs2 = 5'd7;
        #1;
`ifdef WB_FWD_EN
        check("fwd_rd2_match", rd2_fwd, 32'hDEAD_BEEF);
`else
        check("fwd_rd2_match", rd2_fwd, 32'h5555_AAAA);
`endif
        @(negedge clk);
        drive(1, 5'd0, 1, 2'd0, 3'd0, 32'h0000_0999);
        tick();
        rs1 = 5'd0; rd1_raw = 32'h0000_0123;
        #1;
        check("fwd_x0", rd1_fwd, 32'h0000_0123);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
